// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared constants for the multi-channel PWM bank.
//   - CTRL register bit positions (RUN, CENTER, INV).
//   - Register address offsets, expressed as functions of the channel count
//     so every instance size shares one register map definition.
package pwm_bank_pkg;

   // CTRL register bit positions
   localparam int CTRL_RUN    = 0;
   localparam int CTRL_CENTER = 1;
   localparam int CTRL_INV    = 2;
   localparam int CTRL_BITS   = 3;

   // Duty shadow registers occupy addresses DUTY_BASE .. DUTY_BASE+NUM_CH-1
   localparam int DUTY_BASE = 0;

   function automatic int ctrl_ofs(input int num_ch);
      return num_ch;
   endfunction

   function automatic int presc_ofs(input int num_ch);
      return num_ch + 1;
   endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// pwm_channel: one PWM output lane.
//   Holds the double-buffered duty pair (shadow written by the bus, active
//   used for compare), the compare against the shared counter and the
//   registered output.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   wr_i, wdata_i  shadow write strobe / data
//   cnt_i          shared period counter value
//   boundary_i     period boundary: load active from shadow
//   run_i          RUN bit; when low, active tracks shadow and output idles
//   inv_i          output inversion
//   shadow_o       shadow value for register readback
//   pwm_o          registered PWM output
module pwm_channel #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [WIDTH-1:0] cnt_i,
   input  logic             boundary_i,
   input  logic             run_i,
   input  logic             inv_i,
   output logic [WIDTH-1:0] shadow_o,
   output logic             pwm_o
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic             pwm_q, pwm_d;
   logic             raw;

   always_comb begin
      shadow_d = wr_i ? wdata_i : shadow_q;
      // Active samples the pre-write shadow, so a write landing in the
      // boundary cycle only takes effect one period later.
      active_d = (!run_i || boundary_i) ? shadow_q : active_q;
      // Full-scale duty must be solid high; plain cnt < MAX would drop a cycle.
      raw      = (active_q == MAX) || (cnt_i < active_q);
      pwm_d    = run_i ? (raw ^ inv_i) : inv_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign shadow_o = shadow_q;
   assign pwm_o    = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: parametrised multi-channel PWM peripheral.
//   Register port (DUTY shadows, CTRL, PRESC), shared prescaler and
//   period counter with edge- and center-aligned counting, NUM_CH lanes.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   we           register write strobe
//   addr         register address (read and write)
//   wdata        write data
//   rdata        combinational readback of the addressed register
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse aligned with the first output of a period
module pwm_bank
   import pwm_bank_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int WIDTH  = 8,
   localparam int ADDR_W = $clog2(NUM_CH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_tick
);

   localparam logic [WIDTH-1:0] MAX = '1;

   // Counter direction FSM
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_UP   = 2'd1;
   localparam logic [1:0] S_DOWN = 2'd2;

   localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(ctrl_ofs(NUM_CH));
   localparam logic [ADDR_W-1:0] A_PRESC = ADDR_W'(presc_ofs(NUM_CH));

   logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
   logic [WIDTH-1:0]     presc_q, presc_d;
   logic [WIDTH-1:0]     pcnt_q, pcnt_d;
   logic [WIDTH-1:0]     cnt_q, cnt_d;
   logic [1:0]           st_q, st_d;
   logic                 bnd_q, tick_q, tick_d;

   logic                 run, center, inv;
   logic                 ctrl_wr, presc_wr;
   logic                 tick, boundary;

   logic [NUM_CH-1:0]             duty_wr;
   logic [NUM_CH-1:0][WIDTH-1:0]  shadow_w;

   assign run      = ctrl_q[CTRL_RUN];
   assign center   = ctrl_q[CTRL_CENTER];
   assign inv      = ctrl_q[CTRL_INV];
   assign ctrl_wr  = we && (addr == A_CTRL);
   assign presc_wr = we && (addr == A_PRESC);

   always_comb begin
      ctrl_d  = ctrl_wr  ? wdata[CTRL_BITS-1:0] : ctrl_q;
      presc_d = presc_wr ? wdata : presc_q;
   end

   // Prescaler: >= rather than == so a PRESC lowered mid-count below the
   // current pcnt ticks at once instead of wrapping the whole range.
   always_comb begin
      tick   = run && (pcnt_q >= presc_q);
      pcnt_d = (run && !tick) ? pcnt_q + 1'b1 : '0;
   end

   // Period counter / direction
   always_comb begin
      cnt_d    = cnt_q;
      st_d     = st_q;
      boundary = 1'b0;
      if (!run) begin
         cnt_d = '0;
         st_d  = S_IDLE;
      end else begin
         if (st_q == S_IDLE) st_d = S_UP;
         if (tick) begin
            if (!center) begin
               cnt_d    = cnt_q + 1'b1;
               st_d     = S_UP;
               boundary = (cnt_q == MAX);
            end else if (st_q == S_DOWN) begin
               if (cnt_q == '0) begin
                  // only reachable via a mode change; resume upward
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  cnt_d    = cnt_q - 1'b1;
                  boundary = (cnt_q == WIDTH'(1));
               end
               if (cnt_q <= WIDTH'(1)) st_d = S_UP;
            end else begin
               if (cnt_q == MAX) begin
                  cnt_d = MAX - 1'b1;
                  st_d  = S_DOWN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  st_d  = S_UP;
               end
            end
         end
         // A CENTER change mid-run keeps cnt but restarts the direction upward.
         if (ctrl_wr && (wdata[CTRL_CENTER] != center)) st_d = S_UP;
      end
   end

   // Boundary is delayed two stages so the pulse lines up with the first
   // registered output computed from the new period's cnt = 0.
   assign tick_d = bnd_q && run;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q  <= '0;
         presc_q <= '0;
         pcnt_q  <= '0;
         cnt_q   <= '0;
         st_q    <= S_IDLE;
         bnd_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
         cnt_q   <= cnt_d;
         st_q    <= st_d;
         bnd_q   <= boundary;
         tick_q  <= tick_d;
      end
   end

   assign period_tick = tick_q;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      assign duty_wr[n] = we && (addr == ADDR_W'(DUTY_BASE + n));

      pwm_channel #(.WIDTH(WIDTH)) u_ch (
         .clk        (clk),
         .rst        (rst),
         .wr_i       (duty_wr[n]),
         .wdata_i    (wdata),
         .cnt_i      (cnt_q),
         .boundary_i (boundary),
         .run_i      (run),
         .inv_i      (inv),
         .shadow_o   (shadow_w[n]),
         .pwm_o      (pwm_out[n])
      );
   end

   always_comb begin
      rdata = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (addr == ADDR_W'(DUTY_BASE + n)) rdata = shadow_w[n];
      end
      if (addr == A_CTRL)  rdata = WIDTH'(ctrl_q);
      if (addr == A_PRESC) rdata = presc_q;
   end

endmodule

// File: tb/tb_pwm_bank.sv
module tb_pwm_bank;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;
   localparam int ADDR_W = $clog2(NUM_CH) + 1;
   localparam int MAX    = (1 << WIDTH) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              we  = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [WIDTH-1:0]  wdata = '0;
   logic [WIDTH-1:0]  rdata;
   logic [NUM_CH-1:0] pwm_out;
   logic              period_tick;

   pwm_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .pwm_out     (pwm_out),
      .period_tick (period_tick)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks the phase within the period in clocks; the counter value is
   // derived arithmetically from that phase.
   bit                m_run, m_center, m_inv;
   int                m_presc;
   int                m_shadow [NUM_CH];
   int                m_active [NUM_CH];
   int                m_k;
   bit                m_pend;
   logic [NUM_CH-1:0] m_pwm = '0;
   bit                m_tick;

   function automatic int per_len();
      return m_center ? 2 * MAX * (m_presc + 1) : (MAX + 1) * (m_presc + 1);
   endfunction

   function automatic int cnt_at(input int k);
      int t;
      t = k / (m_presc + 1);
      if (!m_center) return t;
      return (t <= MAX) ? t : 2 * MAX - t;
   endfunction

   function automatic logic [WIDTH-1:0] exp_rd(input int a);
      if (a < NUM_CH)      return WIDTH'(m_shadow[a]);
      if (a == NUM_CH)     return WIDTH'({m_inv, m_center, m_run});
      if (a == NUM_CH + 1) return WIDTH'(m_presc);
      return '0;
   endfunction

   task automatic model_reset();
      m_run = 0; m_center = 0; m_inv = 0; m_presc = 0;
      for (int n = 0; n < NUM_CH; n++) begin m_shadow[n] = 0; m_active[n] = 0; end
      m_k = 0; m_pend = 0; m_pwm = '0; m_tick = 0;
   endtask

   task automatic model_step();
      int c;
      bit bnd;
      c   = cnt_at(m_k);
      bnd = m_run && (m_k == per_len() - 1);
      for (int n = 0; n < NUM_CH; n++) begin
         bit raw;
         raw = (m_active[n] == MAX) ? 1'b1 : (c < m_active[n]);
         m_pwm[n] = m_run ? (raw ^ m_inv) : m_inv;
      end
      m_tick = m_pend && m_run;
      m_pend = bnd;
      for (int n = 0; n < NUM_CH; n++)
         if (!m_run || bnd) m_active[n] = m_shadow[n];
      m_k = m_run ? (bnd ? 0 : m_k + 1) : 0;
      if (we) begin
         if (int'(addr) < NUM_CH) m_shadow[addr] = int'(wdata);
         else if (int'(addr) == NUM_CH) begin
            m_run = wdata[0]; m_center = wdata[1]; m_inv = wdata[2];
         end else if (int'(addr) == NUM_CH + 1) m_presc = int'(wdata);
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   // ---------------- per-cycle checker and period statistics ----------------
   int ticks = 0;
   int len = 0, last_len = 0;
   int acc [NUM_CH];
   int last_hi [NUM_CH];

   initial begin
      for (int n = 0; n < NUM_CH; n++) begin acc[n] = 0; last_hi[n] = 0; end
      forever begin
         @(negedge clk);
         #1;
         chk("pwm", 32'(pwm_out), 32'(m_pwm));
         chk("tick", 32'(period_tick), 32'(m_tick));
         chk("rdata", 32'(rdata), 32'(exp_rd(int'(addr))));
         if (period_tick === 1'b1) begin
            ticks++;
            last_len = len;
            len = 0;
            for (int n = 0; n < NUM_CH; n++) begin last_hi[n] = acc[n]; acc[n] = 0; end
         end
         len++;
         for (int n = 0; n < NUM_CH; n++) acc[n] += int'(pwm_out[n]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wr(input int a, input int d);
      @(negedge clk);
      we = 1'b1; addr = ADDR_W'(a); wdata = WIDTH'(d);
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic wait_ticks(input int n);
      int start;
      start = ticks;
      for (int i = 0; i < 12000 && ticks < start + n; i++) begin
         @(negedge clk);
         #2;
      end
      chk("wait_ticks", 32'(ticks >= start + n), 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      // Reset with write traffic: nothing may land
      repeat (10) begin
         @(negedge clk);
         we = 1'b1; addr = ADDR_W'($urandom_range(0, 7)); wdata = WIDTH'($urandom);
      end
      @(negedge clk);
      we = 1'b0;
      for (int a = 0; a < 8; a++) begin
         addr = ADDR_W'(a);
         #1;
         chk("rst_rdata", 32'(rdata), 32'd0);
      end
      chk("rst_pwm", 32'(pwm_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Edge mode, PRESC 0, DUTY0 = 64
      wr(NUM_CH + 1, 0);
      wr(0, 64);
      wr(NUM_CH, 1);
      wait_ticks(3);
      chk("edge_len", last_len, 256);
      chk("edge_hi64", last_hi[0], 64);
      chk("edge_ch1_zero", last_hi[1], 0);
      wr(0, 0);
      wait_ticks(3);
      chk("edge_hi0", last_hi[0], 0);
      wr(0, 255);
      wait_ticks(3);
      chk("edge_hi255", last_hi[0], 256);

      // Double buffering with a write in the boundary cycle
      wr(0, 64);
      wait_ticks(3);
      for (int i = 0; i < 600 && !(m_k == per_len() - 1); i++) begin
         @(negedge clk);
         #2;
      end
      chk("bnd_cycle_found", 32'(m_k == per_len() - 1), 32'd1);
      we = 1'b1; addr = '0; wdata = WIDTH'(192);
      @(negedge clk);
      we = 1'b0;
      wait_ticks(1);
      chk("dbuf_p1", last_hi[0], 64);
      repeat (100) @(negedge clk);
      wr(0, 192);
      wait_ticks(1);
      chk("dbuf_p2", last_hi[0], 64);
      wait_ticks(1);
      chk("dbuf_p3", last_hi[0], 192);

      // Center mode, PRESC 1, DUTY1 = 100: high = (2*duty-1) ticks per period
      wr(NUM_CH, 0);
      wr(NUM_CH + 1, 1);
      wr(1, 100);
      wr(NUM_CH, 3);
      wait_ticks(3);
      chk("ctr_len", last_len, 2 * MAX * 2);
      chk("ctr_hi", last_hi[1], (2 * 100 - 1) * 2);
      chk("ctr_high_at_zero", 32'(pwm_out[1]), 32'd1);

      // INV with four channels
      wr(NUM_CH, 0);
      wr(NUM_CH + 1, 0);
      wr(0, 0); wr(1, 85); wr(2, 170); wr(3, 255);
      wr(NUM_CH, 5);
      wait_ticks(3);
      chk("inv_ch0", last_hi[0], 256);
      chk("inv_ch1", last_hi[1], 171);
      chk("inv_ch2", last_hi[2], 86);
      chk("inv_ch3", last_hi[3], 0);
      wr(NUM_CH, 4);
      repeat (3) @(negedge clk);
      #2;
      chk("inv_idle", 32'(pwm_out), 32'hF);
      chk("inv_idle_tick", 32'(period_tick), 32'd0);

      // Randomised rounds against the model
      for (int r = 0; r < 4; r++) begin
         wr(NUM_CH, 0);
         wr(NUM_CH + 1, $urandom_range(0, 3));
         for (int n = 0; n < NUM_CH; n++) wr(n, $urandom_range(0, MAX));
         wr(NUM_CH, {$urandom_range(0, 1), $urandom_range(0, 1)} << 1 | 1);
         for (int i = 0; i < 2500; i++) begin
            int act;
            @(negedge clk);
            we = 1'b0;
            act = $urandom_range(0, 63);
            if (act < 2) begin
               we = 1'b1; addr = ADDR_W'($urandom_range(0, NUM_CH - 1)); wdata = WIDTH'($urandom);
            end else if (act == 2) begin
               we = 1'b1; addr = ADDR_W'(NUM_CH);
               wdata = WIDTH'({~m_inv, m_center, 1'b1});
            end else if (act == 3) begin
               we = 1'b1; addr = ADDR_W'($urandom_range(NUM_CH + 2, 7)); wdata = WIDTH'($urandom);
            end else begin
               addr = ADDR_W'($urandom_range(0, 7));
            end
         end
         @(negedge clk);
         we = 1'b0;
      end

      // Asynchronous reset between edges while running
      wr(NUM_CH, 0);
      wr(0, 128);
      wr(NUM_CH, 5);
      repeat (300) @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_pwm", 32'(pwm_out), 32'd0);
      chk("arst_tick", 32'(period_tick), 32'd0);
      addr = '0;
      #0.5;
      chk("arst_shadow", 32'(rdata), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("post_rst_idle", 32'(pwm_out), 32'd0);
      wr(2, 8'h5A);
      addr = ADDR_W'(2);
      #2;
      chk("post_rst_wr", 32'(rdata), 32'h5A);
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
